// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcodes, status bit positions and FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_XOR  = 4'd0,
    OP_AND  = 4'd1,
    OP_OR   = 4'd2,
    OP_NOR  = 4'd3,
    OP_ADD  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_ZERO = 4'd7,
    OP_SUB  = 4'd8,
    OP_ASR  = 4'd9,
    OP_MUL  = 4'd10
  } op_e;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int V_BIT = 1;
  localparam int C_BIT = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ASR);
  endfunction

endpackage

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath: logic ops, add/sub and {N,Z,V,C} flags.
// Opcodes it does not implement (shifts, MUL, 11-15) yield result 0 with V=C=0.
module alu_seq_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           flag_v;
  logic           flag_c;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(c_in);
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    flag_v = 1'b0;
    flag_c = 1'b0;
    case (op)
      OP_XOR: result = a ^ b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOR: result = ~(a | b);
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        flag_c = sum[WIDTH];
        flag_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // borrow out of the extended subtract is the inverse of "no borrow" carry
        result = diff[WIDTH-1:0];
        flag_c = ~diff[WIDTH];
        flag_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      default: result = '0;
    endcase
    status        = '0;
    status[N_BIT] = result[WIDTH-1];
    status[Z_BIT] = (result == '0);
    status[V_BIT] = flag_v;
    status[C_BIT] = flag_c;
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: FSM, 1-bit/cycle shifter and optional shift-add multiplier.
// Define ALU_SEQ_MUL_EN to build op 10 as a WIDTH-cycle unsigned multiply.
//
// state | meaning
// IDLE  | waiting for an operation
// BUSY  | iterating a shift or multiply, cnt_q counts down to 0
// DONE  | result/status valid, held until taken
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       status
);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           status_q, status_d;
  logic [3:0]           op_q, op_d;
  logic [SHAMT_W-1:0]   cnt_q, cnt_d;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]       mul_sum;
`endif

  logic [WIDTH-1:0]     comb_result;
  logic [3:0]           comb_status;
  logic [WIDTH-1:0]     shift_step;
  logic [SHAMT_W-1:0]   amt;
  logic                 sat;
  logic                 accept;
  logic                 mul_v;

  alu_seq_comb #(.WIDTH(WIDTH)) u_comb (
    .op     (op),
    .a      (a),
    .b      (b),
    .c_in   (c_in),
    .result (comb_result),
    .status (comb_status)
  );

  assign amt       = b[SHAMT_W-1:0];
  assign sat       = |b[WIDTH-1:SHAMT_W];
  assign in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign status    = status_q;

  always_comb begin
    case (op_q)
      OP_SHL:  shift_step = {result_q[WIDTH-2:0], 1'b0};
      OP_SHR:  shift_step = {1'b0, result_q[WIDTH-1:1]};
      OP_ASR:  shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
      default: shift_step = result_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    status_d = status_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    mul_v    = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mul_sum  = '0;
`endif

    case (state_q)
      BUSY: begin
`ifdef ALU_SEQ_MUL_EN
        if (op_q == OP_MUL) begin
          mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
          prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
        end else
`endif
          result_d = shift_step;
        if (cnt_q == '0) begin
          state_d = DONE;
`ifdef ALU_SEQ_MUL_EN
          if (op_q == OP_MUL) begin
            result_d = prod_d[WIDTH-1:0];
            mul_v    = |prod_d[2*WIDTH-1:WIDTH];
          end
`endif
          status_d        = '0;
          status_d[N_BIT] = result_d[WIDTH-1];
          status_d[Z_BIT] = (result_d == '0);
          status_d[V_BIT] = mul_v;
        end else begin
          cnt_d = cnt_q - SHAMT_W'(1);
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = state_q;
    endcase

    // A new accept (from IDLE, or back-to-back from DONE) overrides the above.
    if (accept) begin
      op_d     = op;
      cnt_d    = '0;
      state_d  = DONE;
      result_d = comb_result;
      status_d = comb_status;
      if (is_shift(op)) begin
        if (sat) begin
          result_d = (op == OP_ASR) ? {WIDTH{a[WIDTH-1]}} : '0;
        end else begin
          result_d = a;
          if (amt != '0) begin
            cnt_d   = amt - SHAMT_W'(1);
            state_d = BUSY;
          end
        end
        status_d        = '0;
        status_d[N_BIT] = result_d[WIDTH-1];
        status_d[Z_BIT] = (result_d == '0);
      end
`ifdef ALU_SEQ_MUL_EN
      else if (op == OP_MUL) begin
        state_d  = BUSY;
        cnt_d    = '1;
        mcand_d  = a;
        prod_d   = {{WIDTH{1'b0}}, b};
        result_d = '0;
        status_d = '0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      status_q <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= '0;
      prod_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      status_q <= status_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
`ifdef ALU_SEQ_MUL_EN
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
`endif
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq (WIDTH=32); MUL expectations follow ALU_SEQ_MUL_EN.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  status;

  int checks = 0;
  int errors = 0;
  int lat;
  int nrdy;

  alu_seq #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .status    (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one op at a negedge, hold for one edge, then wait (bounded) for out_valid.
  task automatic do_op(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, output int l, output int nr);
    @(negedge clk);
    in_valid = 1'b1;
    op = o;
    a = av;
    b = bv;
    c_in = ci;
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF;
    b = 32'h0BAD_F00D;
    l = 1;
    nr = 0;
    while (!out_valid && l < 200) begin
      if (!in_ready) nr++;
      @(posedge clk);
      #1;
      l++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    op = 4'd0;
    a = '0;
    b = '0;
    c_in = 1'b0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_status", status, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1);

    do_op(4'd4, 32'h7FFF_FFFF, 32'h1, 1'b0, lat, nrdy);
    check("add_ovf_res", result, 32'h8000_0000);
    check("add_ovf_st", status, 4'b1010);
    check("add_ovf_lat", lat, 1);

    do_op(4'd4, 32'hFFFF_FFFF, 32'h0, 1'b1, lat, nrdy);
    check("add_cin_res", result, 32'h0);
    check("add_cin_st", status, 4'b0101);

    do_op(4'd8, 32'h5, 32'h5, 1'b0, lat, nrdy);
    check("sub_eq_res", result, 32'h0);
    check("sub_eq_st", status, 4'b0101);

    do_op(4'd8, 32'h0, 32'h1, 1'b0, lat, nrdy);
    check("sub_neg_res", result, 32'hFFFF_FFFF);
    check("sub_neg_st", status, 4'b1000);

    do_op(4'd2, 32'h0F0, 32'h00F, 1'b0, lat, nrdy);
    check("or_res", result, 32'h0FF);
    check("or_st", status, 4'b0000);

    do_op(4'd3, 32'h0, 32'h0, 1'b0, lat, nrdy);
    check("nor_res", result, 32'hFFFF_FFFF);
    check("nor_st", status, 4'b1000);

    do_op(4'd7, 32'h123, 32'h456, 1'b1, lat, nrdy);
    check("zero_res", result, 32'h0);
    check("zero_st", status, 4'b0100);

    do_op(4'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, lat, nrdy);
    check("illegal_res", result, 32'h0);
    check("illegal_st", status, 4'b0100);
    check("illegal_lat", lat, 1);

    do_op(4'd5, 32'h1, 32'd5, 1'b0, lat, nrdy);
    check("shl5_res", result, 32'h20);
    check("shl5_st", status, 4'b0000);
    check("shl5_lat", lat, 6);
    check("shl5_busy", nrdy, 5);

    do_op(4'd6, 32'h8000_0000, 32'd31, 1'b0, lat, nrdy);
    check("shr31_res", result, 32'h1);
    check("shr31_lat", lat, 32);

    do_op(4'd9, 32'h8000_0000, 32'h40, 1'b0, lat, nrdy);
    check("asr_sat_res", result, 32'hFFFF_FFFF);
    check("asr_sat_st", status, 4'b1000);
    check("asr_sat_lat", lat, 1);

    do_op(4'd9, 32'h8000_0000, 32'd4, 1'b0, lat, nrdy);
    check("asr4_res", result, 32'hF800_0000);
    check("asr4_lat", lat, 5);

    do_op(4'd5, 32'h1234_5678, 32'd0, 1'b0, lat, nrdy);
    check("shl0_res", result, 32'h1234_5678);
    check("shl0_lat", lat, 1);

    do_op(4'd5, 32'h1, 32'd32, 1'b0, lat, nrdy);
    check("shl_sat_res", result, 32'h0);
    check("shl_sat_st", status, 4'b0100);
    check("shl_sat_lat", lat, 1);

    do_op(4'd10, 32'h0001_0000, 32'h0001_0000, 1'b0, lat, nrdy);
`ifdef ALU_SEQ_MUL_EN
    check("mul_big_res", result, 32'h0);
    check("mul_big_st", status, 4'b0110);
    check("mul_big_lat", lat, 33);
`else
    check("mul_off_res", result, 32'h0);
    check("mul_off_st", status, 4'b0100);
    check("mul_off_lat", lat, 1);
`endif

    do_op(4'd10, 32'd3, 32'd5, 1'b0, lat, nrdy);
`ifdef ALU_SEQ_MUL_EN
    check("mul_small_res", result, 32'd15);
    check("mul_small_st", status, 4'b0000);
`else
    check("mul_off2_res", result, 32'h0);
`endif

    // take the pending result, then confirm nothing happens with in_valid low
    @(negedge clk);
    @(posedge clk);
    #1;
    check("idle_out_valid", out_valid, 0);

    out_ready = 1'b0;
    do_op(4'd0, 32'hF0, 32'hFF, 1'b0, lat, nrdy);
    check("bp_xor_lat", lat, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_res", result, 32'h0F);
      check("bp_hold_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1;
    op = 4'd1;
    a = 32'h0000_FF00;
    b = 32'h0000_0FF0;
    #1;
    check("bp_take_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("b2b_valid", out_valid, 1);
    check("b2b_and_res", result, 32'h0000_0F00);

    @(negedge clk);
    in_valid = 1'b1;
    op = 4'd5;
    a = 32'h1;
    b = 32'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_busy", out_valid, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_busy_valid", out_valid, 0);
    check("rst_busy_res", result, 32'h0);
    check("rst_busy_st", status, 4'b0000);
    check("rst_busy_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", in_ready, 1);

    do_op(4'd4, 32'd2, 32'd3, 1'b1, lat, nrdy);
    check("post_rst_add", result, 32'd6);
    check("post_rst_lat", lat, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
